// File: rtl/alu_mdu_pipe.sv
// Execute unit: single-cycle integer ALU plus an iterative radix-2 mul/div,
// with a valid/ready handshake on both sides and flush support.
module alu_mdu_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OP_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] src3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state, state_nx;
  logic [4:0]        opc;
  logic              accept, is_mdu, last;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              sa, sb, dz;
  logic [XLEN-1:0]   hi, lo, mcand;
  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [XLEN-1:0]   alu_res, mdu_res;
  logic [CW-1:0]     shamt;
  logic              is_div_in, a_sgn_in, b_sgn_in, sa_in, sb_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign opc       = op[4:0];
  assign is_mdu    = (opc[4:3] == 2'b11);
  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign last      = (cnt == CW'(XLEN - 1));
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY);
  assign shamt     = src2[CW-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a result leaving DONE may be replaced by a new accept
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nx = is_mdu ? S_BUSY : S_DONE;
        S_BUSY:  if (last) state_nx = S_DONE;
        S_DONE: begin
          if (accept)         state_nx = is_mdu ? S_BUSY : S_DONE;
          else if (out_ready) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Single-cycle ALU on the live operands
  always_comb begin
    alu_res = src1 + src2;
    case (opc)
      5'h01: alu_res = src2;
      5'h02: alu_res = src1 - src2;
      5'h03: alu_res = (src1 + src2) & ~XLEN'(1);
      5'h04: alu_res = XLEN'(src1 < src2);
      5'h05: alu_res = src1 ^ src2;
      5'h06: alu_res = src1 | src2;
      5'h07: alu_res = src1 & src2;
      5'h08: alu_res = src1 << shamt;
      5'h09: alu_res = $signed(src1) >>> shamt;
      5'h0A: alu_res = src1 >> shamt;
      5'h0C: alu_res = XLEN'($signed(src1) < $signed(src2));
      5'h0D: alu_res = XLEN'(src1 == src2);
      5'h0E: alu_res = XLEN'($signed(src1) >= $signed(src2));
      5'h0F: alu_res = XLEN'(src1 >= src2);
      5'h10: alu_res = XLEN'($signed(src1) < $signed(src2));
      5'h11: alu_res = XLEN'(src1 < src2);
      5'h12: alu_res = XLEN'(src1 != src2);
      5'h16: alu_res = src1 | src3;
      5'h17: alu_res = src1;
      default: alu_res = src1 + src2;
    endcase
  end

  // Operand signedness and magnitudes for the mul/div setup
  always_comb begin
    is_div_in = opc[2];
    a_sgn_in  = is_div_in ? !opc[0] : (opc[1:0] != 2'b11);
    b_sgn_in  = is_div_in ? !opc[0] : !opc[1];
    sa_in     = a_sgn_in && src1[XLEN-1];
    sb_in     = b_sgn_in && src2[XLEN-1];
    mag_a     = sa_in ? ('0 - src1) : src1;
    mag_b     = sb_in ? ('0 - src2) : src2;
  end

  // One radix-2 step: shift-add multiply or restoring divide, sharing hi/lo.
  // The restoring remainder never exceeds XLEN bits, so bit XLEN is dropped.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (!op_q[2]) begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      hi_nx = div_diff[XLEN-1:0];
      lo_nx = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_nx = div_shift[XLEN-1:0];
      lo_nx = {lo[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix applied to the final step; divide-by-zero keeps an all-ones quotient
  always_comb begin
    prod     = {hi_nx, lo_nx};
    prod_fix = (sa ^ sb) ? ('0 - prod) : prod;
    quo_fix  = ((sa ^ sb) && !dz) ? ('0 - lo_nx) : lo_nx;
    rem_fix  = sa ? ('0 - hi_nx) : hi_nx;
    if (!op_q[2]) mdu_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else          mdu_res = op_q[1] ? rem_fix : quo_fix;
  end

  // Datapath: capture at accept, iterate while busy, register the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      cnt    <= '0;
      op_q   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      if (is_mdu) begin
        op_q  <= opc[2:0];
        sa    <= sa_in;
        sb    <= sb_in;
        dz    <= (src2 == '0);
        cnt   <= '0;
        hi    <= '0;
        lo    <= is_div_in ? mag_a : mag_b;
        mcand <= is_div_in ? mag_b : mag_a;
      end else begin
        result <= alu_res;
      end
    end else if (state == S_BUSY) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) result <= mdu_res;
    end
  end

endmodule
